alu_host_driver: RTL and testbench

//  Initiator side of the serial ALU operand/result protocol. Accepts one

---
 rtl/alu_host_driver.sv | 135 +++++++++++++
 tb/tb_alu_host_driver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_host_driver.sv
// alu_host_driver: serializes one (op, M, Q) request onto the ALU pins and collects its 1- or 2-byte result.
// Every ALU-side and response output is a register; req_ready is decoded from the state.
module alu_host_driver #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_m,
  input  logic [7:0] req_q,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_hi,
  output logic [7:0] rsp_lo,
  output logic       rsp_ovf,
  output logic       rsp_err,
  output logic       alu_start,
  output logic [1:0] alu_s,
  output logic [7:0] alu_inbus,
  input  logic [7:0] alu_outbus,
  input  logic       alu_finish,
  input  logic       alu_overflow
);
  typedef enum logic [2:0] {IDLE, SEND_M, SEND_Q, WAIT, SECOND, RESP} state_t;
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);
  state_t     state_q, state_d;
  logic [7:0] q_q, q_d, timer_q, timer_d, inbus_q, inbus_d, hi_q, hi_d, lo_q, lo_d;
  logic [1:0] s_q, s_d;
  logic       start_q, start_d, ovf_q, ovf_d, err_q, err_d, valid_q, valid_d;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      q_q     <= '0;
      timer_q <= '0;
      inbus_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      s_q     <= '0;
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      timer_q <= timer_d;
      inbus_q <= inbus_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      s_q     <= s_d;
      start_q <= start_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end
  // alu_s doubles as the latched opcode for the whole transaction
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    timer_d = timer_q;
    inbus_d = inbus_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    s_d     = s_q;
    start_d = start_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = SEND_M;
        start_d = 1'b1;
        s_d     = req_op;
        inbus_d = req_m;
        q_d     = req_q;
        hi_d    = '0;
        lo_d    = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
      end
      SEND_M: begin
        state_d = SEND_Q;
        start_d = 1'b0;
        inbus_d = q_q;
      end
      SEND_Q: begin
        state_d = WAIT;
        inbus_d = '0;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        if (alu_finish) begin
          ovf_d   = alu_overflow;
          hi_d    = s_q[1] ? alu_outbus : {8{alu_outbus[7]}};
          lo_d    = s_q[1] ? lo_q : alu_outbus;
          state_d = s_q[1] ? SECOND : RESP;
          valid_d = !s_q[1];
        end else if (timer_q == TLAST) begin
          err_d   = 1'b1;
          hi_d    = '0;
          lo_d    = '0;
          ovf_d   = 1'b0;
          state_d = RESP;
          valid_d = 1'b1;
        end
      end
      SECOND: begin
        state_d = RESP;
        valid_d = 1'b1;
        lo_d    = alu_finish ? alu_outbus : 8'h00;
        hi_d    = alu_finish ? hi_q : 8'h00;
        err_d   = !alu_finish;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = valid_q;
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_err   = err_q;
  assign alu_start = start_q;
  assign alu_s     = s_q;
  assign alu_inbus = inbus_q;
endmodule

// File: tb/tb_alu_host_driver.sv
// tb_alu_host_driver: drives alu_host_driver against a behavioural ALU and scoreboards every response.
module tb_alu_host_driver;
  logic       clk = 1'b0, rst_b = 1'b0;
  logic       req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
  logic [1:0] req_op = '0, alu_s;
  logic [7:0] req_m = '0, req_q = '0, rsp_hi, rsp_lo, alu_inbus, alu_outbus;
  logic       rsp_ovf, rsp_err, alu_start, alu_finish, alu_overflow;
  int         n_chk = 0, n_fail = 0, alu_lat = 0;
  logic       alu_stub = 1'b0, alu_short = 1'b0;
  logic [17:0] sb[$];
  int         cyc;

  alu_host_driver #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_m(req_m), .req_q(req_q), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_ovf(rsp_ovf),
    .rsp_err(rsp_err), .alu_start(alu_start), .alu_s(alu_s), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_finish(alu_finish), .alu_overflow(alu_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // {first byte, second byte, overflow}; add/sub is Q+/-M, mul signed, div Q/M unsigned
  function automatic logic [16:0] alu_calc(input logic [1:0] op, input logic [7:0] m, input logic [7:0] q);
    logic [7:0]  r;
    logic [15:0] p;
    case (op)
      2'd0: begin r = q + m; return {r, 8'h00, (q[7] == m[7]) && (r[7] != q[7])}; end
      2'd1: begin r = q - m; return {r, 8'h00, (q[7] != m[7]) && (r[7] != q[7])}; end
      2'd2: begin p = 16'($signed(m) * $signed(q)); return {p, 1'b0}; end
      default: return (m == 0) ? {q, 8'hFF, 1'b0} : {q % m, q / m, 1'b0};
    endcase
  endfunction

  function automatic logic [17:0] exp_rsp(input logic [1:0] op, input logic [7:0] m, input logic [7:0] q);
    logic [16:0] r;
    r = alu_calc(op, m, q);
    return op[1] ? {r[16:1], r[0], 1'b0} : {{8{r[16]}}, r[16:9], r[0], 1'b0};
  endfunction

  initial begin
    logic [1:0]  s;
    logic [7:0]  m, q;
    logic [16:0] r;
    alu_finish = 1'b0; alu_outbus = '0; alu_overflow = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (alu_start && rst_b) begin
        s = alu_s; m = alu_inbus;
        @(posedge clk); #1;
        q = alu_inbus;
        r = alu_calc(s, m, q);
        if (!alu_stub) begin
          repeat (alu_lat + 1) begin @(posedge clk); #1; end
          alu_finish = 1'b1; alu_outbus = r[16:9]; alu_overflow = r[0];
          @(posedge clk); #1;
          if (s[1] && !alu_short) begin
            alu_outbus = r[8:1]; alu_overflow = 1'b0;
            @(posedge clk); #1;
          end
          alu_finish = 1'b0; alu_outbus = '0; alu_overflow = 1'b0;
        end
      end
    end
  end

  task automatic run(input logic [1:0] op, input logic [7:0] m, input logic [7:0] q,
                     input logic [17:0] want, input int lat, input int hold, output int cycles);
    logic [17:0] e;
    alu_lat = lat;
    req_op = op; req_m = m; req_q = q; req_valid = 1'b1;
    sb.push_back(want);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("send_m", {alu_start, alu_s, alu_inbus}, {1'b1, op, m});
    @(posedge clk); #1;
    chk("send_q", {alu_start, alu_s, alu_inbus}, {1'b0, op, q});
    cycles = 0;
    while (!rsp_valid && cycles < 200) begin @(posedge clk); #1; cycles++; end
    chk("rsp_seen", rsp_valid, 1);
    e = sb.pop_front();
    chk("rsp", {rsp_hi, rsp_lo, rsp_ovf, rsp_err}, e);
    req_valid = (hold > 0); req_op = 2'd2; req_m = 8'h55; req_q = 8'hAA;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold", {rsp_valid, req_ready, alu_start, rsp_hi, rsp_lo, rsp_ovf, rsp_err}, {3'b100, e});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, req_ready, alu_s}, 4'b0100);
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] m, q;
    #12;
    chk("reset", {req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_ovf, rsp_err, alu_start, alu_s, alu_inbus},
        {1'b1, 30'h0});
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    run(2'd0, 8'h39, 8'h43, {8'h00, 8'h7C, 2'b00}, 0, 0, cyc);
    run(2'd0, 8'h7F, 8'h7E, {8'hFF, 8'hFD, 2'b10}, 2, 0, cyc);
    run(2'd1, 8'h01, 8'h80, {8'h00, 8'h7F, 2'b10}, 0, 0, cyc);
    run(2'd2, 8'hA3, 8'h8D, {8'h29, 8'hC7, 2'b00}, 1, 0, cyc);
    run(2'd2, 8'h59, 8'h9F, {8'hDE, 8'h47, 2'b00}, 0, 0, cyc);
    run(2'd3, 8'h0D, 8'hD9, {8'h09, 8'h10, 2'b00}, 3, 0, cyc);
    run(2'd1, 8'h10, 8'h05, {8'hFF, 8'hF5, 2'b00}, 15, 0, cyc);
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3)); m = 8'($urandom_range(1, 255)); q = 8'($urandom);
      run(op, m, q, exp_rsp(op, m, q), int'($urandom_range(0, 6)), 0, cyc);
    end
    alu_short = 1'b1;
    run(2'd2, 8'h12, 8'h34, {8'h00, 8'h00, 2'b01}, 0, 0, cyc);
    alu_short = 1'b0;
    alu_stub = 1'b1;
    run(2'd0, 8'h01, 8'h02, {8'h00, 8'h00, 2'b01}, 0, 0, cyc);
    chk("timeout_cycles", cyc, 17);
    req_op = 2'd2; req_m = 8'hA3; req_q = 8'h8D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_b = 1'b0;
    #1;
    chk("mid_reset", {req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_ovf, rsp_err, alu_start, alu_s, alu_inbus},
        {1'b1, 30'h0});
    @(posedge clk); #1;
    rst_b = 1'b1;
    alu_stub = 1'b0;
    @(posedge clk); #1;
    run(2'd0, 8'h22, 8'h11, {8'h00, 8'h33, 2'b00}, 1, 5, cyc);
    repeat (3) begin @(posedge clk); #1; end
    chk("final_idle", {req_ready, rsp_valid, alu_start}, 3'b100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
